// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder: FSM states, nibble width
// and the nibble-count helper.
package nsa_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int nibble_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_add4.sv
// Combinational 4-bit ripple-carry adder built from a chain of full-adder cells.
// c[i] is the carry out of bit i, so c[3] is the nibble carry-out.
module nibble_add4
  import nsa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic [NIBBLE_W-1:0] c
);

  always_comb begin
    logic cy;
    cy = cin;
    s  = '0;
    c  = '0;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s[i] = a[i] ^ b[i] ^ cy;
      c[i] = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
      cy   = c[i];
    end
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder processing one nibble per clock through a single
// nibble_add4. Define NSA_OVERFLOW_EN to enable the signed-overflow output.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = nibble_count(WIDTH);
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  state_t                    state, state_next;
  logic [KW-1:0]             k;
  logic [WIDTH-1:0]          a_sh, b_sh, sum_sh;
  logic                      carry_reg, cout_reg;
  logic [NIBBLE_W-1:0]       nib_s, nib_c;
  logic [WIDTH+NIBBLE_W-1:0] sum_cat;
  logic                      last_nib;

  nibble_add4 u_add (
    .a  (a_sh[NIBBLE_W-1:0]),
    .b  (b_sh[NIBBLE_W-1:0]),
    .cin(carry_reg),
    .s  (nib_s),
    .c  (nib_c)
  );

  assign last_nib = (k == KW'(N - 1));
  // New nibble enters at the top so after N shifts nibble 0 sits at the bottom.
  assign sum_cat  = {nib_s, sum_sh};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last_nib) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      k         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh      <= a;
            b_sh      <= b;
            carry_reg <= cin;
            k         <= '0;
          end
        end
        RUN: begin
          sum_sh    <= sum_cat[WIDTH+NIBBLE_W-1:NIBBLE_W];
          a_sh      <= a_sh >> NIBBLE_W;
          b_sh      <= b_sh >> NIBBLE_W;
          carry_reg <= nib_c[NIBBLE_W-1];
          k         <= k + 1'b1;
          if (last_nib) cout_reg <= nib_c[NIBBLE_W-1];
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_sh;
  assign cout = cout_reg;

`ifdef NSA_OVERFLOW_EN
  logic       ovf_reg;
  logic [1:0] unused_carries;

  // Signed overflow: carry into the MSB disagrees with carry out of it.
  always_ff @(posedge clk) begin
    if (!rst_n)                     ovf_reg <= 1'b0;
    else if (state == RUN && last_nib) ovf_reg <= nib_c[3] ^ nib_c[2];
  end

  assign ovf            = ovf_reg;
  assign unused_carries = nib_c[1:0];
`else
  logic [2:0] unused_carries;

  assign ovf            = 1'b0;
  assign unused_carries = nib_c[2:0];
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16) against an arithmetic
// reference model; honours NSA_OVERFLOW_EN when it is defined for the build.
module tb_nibble_serial_adder;

  localparam int WIDTH   = 16;
  localparam int N       = WIDTH / 4;
  localparam int MAXWAIT = 20;
`ifdef NSA_OVERFLOW_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  // Reference: exact integer addition, signed range check for overflow.
  function automatic void model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                input logic c, output logic [WIDTH-1:0] s,
                                output logic co, output logic ov);
    longint unsigned full;
    longint          sx, sy, sres;
    full = longint'(x) + longint'(y) + longint'(c);
    s    = WIDTH'(full % (64'd1 << WIDTH));
    co   = (full >= (64'd1 << WIDTH));
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    sres = sx + sy + longint'(c);
    ov   = OVF_ON && ((sres > 32767) || (sres < -32768));
  endfunction

  // Presents one operand pair, scrambles inputs after acceptance and waits
  // (bounded) for out_valid; lat is the number of edges after the accept edge.
  task automatic send_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic c, output int lat);
    a = x; b = y; cin = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a   = WIDTH'($urandom());
    b   = WIDTH'($urandom());
    cin = 1'($urandom());
    lat = 0;
    while (!out_valid && lat < MAXWAIT) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    a = 16'hBEEF; b = 16'h1234;
    rst_n = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++;
    if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      fails++;
      $display("[TB] FAIL reset_state: got rdy=%b vld=%b sum=%h cout=%b ovf=%b, expected rdy=1 vld=0 sum=0000 cout=0 ovf=0",
               in_ready, out_valid, sum, cout, ovf);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_priority: got rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] va [3] = '{16'h1234, 16'hFFFF, 16'h7FFF};
    logic [WIDTH-1:0] vb [3] = '{16'h4321, 16'h0001, 16'h0001};
    logic [WIDTH-1:0] es [3] = '{16'h5555, 16'h0000, 16'h8000};
    logic             ec [3] = '{1'b0, 1'b1, 1'b0};
    logic             eo [3] = '{1'b0, 1'b0, OVF_ON};
    int lat;
    for (int i = 0; i < 3; i++) begin
      send_op(va[i], vb[i], 1'b0, lat);
      tests++;
      if (lat !== N) begin
        fails++;
        $display("[TB] FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, N);
      end
      tests++;
      if ({sum, cout, ovf} !== {es[i], ec[i], eo[i]}) begin
        fails++;
        $display("[TB] FAIL directed_result[%0d]: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                 i, sum, cout, ovf, es[i], ec[i], eo[i]);
      end
      consume();
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        fails++;
        $display("[TB] FAIL directed_release[%0d]: got rdy=%b vld=%b expected rdy=1 vld=0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] es, hs;
    logic             ec, eo, hc, ho;
    int lat;
    model(16'h8001, 16'h8002, 1'b1, es, ec, eo);
    send_op(16'h8001, 16'h8002, 1'b1, lat);
    hs = sum; hc = cout; ho = ovf;
    tests++;
    if ({hs, hc, ho} !== {es, ec, eo}) begin
      fails++;
      $display("[TB] FAIL bp_result: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
               hs, hc, ho, es, ec, eo);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      a = WIDTH'($urandom());
      b = WIDTH'($urandom());
      @(posedge clk); #1;
      tests++;
      if ({out_valid, in_ready, sum, cout, ovf} !== {1'b1, 1'b0, es, ec, eo}) begin
        fails++;
        $display("[TB] FAIL bp_hold[%0d]: got vld=%b rdy=%b sum=%h cout=%b ovf=%b expected vld=1 rdy=0 sum=%h cout=%b ovf=%b",
                 i, out_valid, in_ready, sum, cout, ovf, es, ec, eo);
      end
    end
    in_valid = 1'b0;
    consume();
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL bp_ready_after: got %b expected 1", in_ready);
    end
    model(16'h0F0F, 16'h00F1, 1'b0, es, ec, eo);
    send_op(16'h0F0F, 16'h00F1, 1'b0, lat);
    tests++;
    if ({lat, sum, cout, ovf} !== {N, es, ec, eo}) begin
      fails++;
      $display("[TB] FAIL bp_next_op: got lat=%0d sum=%h cout=%b ovf=%b expected lat=%0d sum=%h cout=%b ovf=%b",
               lat, sum, cout, ovf, N, es, ec, eo);
    end
    consume();
  endtask

  task automatic test_reset_midrun();
    bit seen_valid = 1'b0;
    a = 16'hAAAA; b = 16'h5555; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tests++;
    if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      fails++;
      $display("[TB] FAIL midrun_reset: got rdy=%b vld=%b sum=%h cout=%b ovf=%b expected rdy=1 vld=0 sum=0000 cout=0 ovf=0",
               in_ready, out_valid, sum, cout, ovf);
    end
    for (int i = 0; i < 2 * N; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    tests++;
    if (seen_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midrun_no_result: got out_valid seen=%b expected 0", seen_valid);
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] x, y, es;
    logic             c, ec, eo;
    int lat, stall;
    for (int i = 0; i < 24; i++) begin
      x = WIDTH'($urandom());
      y = (i % 4 == 0) ? ~x : WIDTH'($urandom());
      c = 1'($urandom());
      model(x, y, c, es, ec, eo);
      send_op(x, y, c, lat);
      tests++;
      if ({lat, sum, cout, ovf} !== {N, es, ec, eo}) begin
        fails++;
        $display("[TB] FAIL random[%0d] %h+%h+%b: got lat=%0d sum=%h cout=%b ovf=%b expected lat=%0d sum=%h cout=%b ovf=%b",
                 i, x, y, c, lat, sum, cout, ovf, N, es, ec, eo);
      end
      stall = $urandom_range(0, 3);
      repeat (stall) @(posedge clk);
      #1;
      tests++;
      if ({out_valid, sum} !== {1'b1, es}) begin
        fails++;
        $display("[TB] FAIL random_stall[%0d]: got vld=%b sum=%h expected vld=1 sum=%h", i, out_valid, sum, es);
      end
      consume();
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] x, y, es;
    logic             c, ec, eo;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      x = WIDTH'($urandom());
      y = WIDTH'($urandom());
      c = 1'($urandom());
      model(x, y, c, es, ec, eo);
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("[TB] FAIL b2b_ready[%0d]: got %b expected 1", i, in_ready);
      end
      a = x; b = y; cin = c; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < MAXWAIT) begin
        @(posedge clk); #1;
        lat++;
      end
      tests++;
      if ({lat, sum, cout, ovf} !== {N, es, ec, eo}) begin
        fails++;
        $display("[TB] FAIL b2b_result[%0d]: got lat=%0d sum=%h cout=%b ovf=%b expected lat=%0d sum=%h cout=%b ovf=%b",
                 i, lat, sum, cout, ovf, N, es, ec, eo);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midrun();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
